// File: rtl/data_memory_responder_if.sv
// Cache-side ext_mem handshake bundle: one line-sized request, one ack pulse.
interface data_memory_responder_if;
    logic         cs_i;
    logic         we_i;
    logic [31:0]  addr_i;
    logic [255:0] data_i;
    logic         ack_o;
    logic [255:0] data_o;

    modport master (
        output cs_i, we_i, addr_i, data_i,
        input  ack_o, data_o
    );

    modport slave (
        input  cs_i, we_i, addr_i, data_i,
        output ack_o, data_o
    );
endinterface

// File: rtl/data_memory_responder.sv
// Line-granular external memory responder: accepts one 256-bit line read or
// write per request and acknowledges a fixed LATENCY edges after acceptance.
module data_memory_responder #(
    parameter int unsigned LINE_BITS = 8,
    parameter int unsigned LATENCY   = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    data_memory_responder_if.slave  bus
);

    localparam int unsigned DEPTH = 1 << LINE_BITS;
    localparam logic [7:0]  LOAD  = 8'(LATENCY - 1);

    generate
        if ((LATENCY < 1) || (LATENCY > 255)) begin : g_bad_latency
            $error("data_memory_responder: LATENCY must be in 1..255");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACK
    } state_t;

    state_t                 r_state;
    logic [7:0]             r_count;
    logic                   r_we;
    logic [LINE_BITS-1:0]   r_idx;
    logic [255:0]           r_wdata;
    logic [255:0]           r_rdata;
    logic                   r_ack;
    logic [255:0]           r_mem [DEPTH];

    logic [LINE_BITS-1:0]   w_idx;
    logic                   w_unused_addr;

    assign w_idx         = bus.addr_i[LINE_BITS+4:5];
    assign w_unused_addr = ^{bus.addr_i[31:LINE_BITS+5], bus.addr_i[4:0]};

    assign bus.ack_o  = r_ack;
    assign bus.data_o = r_rdata;

    // Request FSM: capture in IDLE, count down in WAIT, one-cycle ACK.
    // Every request passes through WAIT (also for LATENCY=1) so the ack
    // lands exactly LATENCY edges after the accepting edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_count <= '0;
            r_ack   <= 1'b0;
            r_rdata <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_ack <= 1'b0;
                    if (bus.cs_i) begin
                        r_we    <= bus.we_i;
                        r_idx   <= w_idx;
                        r_wdata <= bus.data_i;
                        r_count <= LOAD;
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (r_count == 8'd0) begin
                        r_state <= S_ACK;
                        r_ack   <= 1'b1;
                        if (!r_we) begin
                            r_rdata <= r_mem[r_idx];
                        end
                    end else begin
                        r_count <= r_count - 8'd1;
                    end
                end
                S_ACK: begin
                    r_ack   <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_ack   <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Line array: a write commits on the edge leaving ACK; never reset.
    always_ff @(posedge clk) begin
        if (rst && (r_state == S_ACK) && r_we) begin
            r_mem[r_idx] <= r_wdata;
        end
    end

endmodule

// File: tb/tb_data_memory_responder.sv
// Self-checking bench for data_memory_responder (LATENCY=10 and LATENCY=1).
module tb_data_memory_responder;

    localparam int unsigned LAT = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    int unsigned cyc = 0;
    int          total = 0;
    int          bad = 0;

    localparam logic [255:0] P_DEAD = {8{32'hDEAD_BEEF}};
    localparam logic [255:0] P_ONE  = {4{64'hCAFE_F00D_0BAD_C0DE}};
    localparam logic [255:0] P_FIVE = {16{16'hA5C3}};
    localparam logic [255:0] P_Q    = {8{32'h1357_9BDF}};
    localparam logic [255:0] P_R    = {8{32'h2468_ACE0}};

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    data_memory_responder_if bus_a ();
    data_memory_responder_if bus_b ();

    data_memory_responder #(.LINE_BITS(8), .LATENCY(LAT)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_a.slave)
    );

    data_memory_responder #(.LINE_BITS(8), .LATENCY(1)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus_b.slave)
    );

    typedef struct {
        bit          is_read;
        logic [255:0] data;
        int unsigned ack_cyc;
    } sb_t;

    sb_t sb[$];
    sb_t mon_e;

    typedef struct {
        bit           we;
        logic [31:0]  addr;
        logic [255:0] data;
        logic [255:0] exp;
    } vec_t;

    vec_t vec[8];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Scoreboard monitor for the LATENCY=10 instance.
    logic prev_ack_a = 1'b0;
    always @(negedge clk) begin
        if (prev_ack_a) chk("ack_width", 256'(bus_a.ack_o), 256'(0));
        if (bus_a.ack_o === 1'b1) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL spurious_ack @cyc %0d: got ack, expected none", cyc);
            end else begin
                mon_e = sb.pop_front();
                chk("ack_time", 256'(cyc), 256'(mon_e.ack_cyc));
                if (mon_e.is_read) chk("rd_data", bus_a.data_o, mon_e.data);
            end
        end
        prev_ack_a = bus_a.ack_o;
    end

    task automatic wait_ack(input bit sel, output int unsigned c);
        c = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if ((sel ? bus_b.ack_o : bus_a.ack_o) === 1'b1) begin
                c = cyc;
                return;
            end
        end
        total++;
        bad++;
        $display("FAIL ack_timeout: got no ack in 400 cycles, expected one (bus %0d)", sel);
    endtask

    task automatic req_a(input bit we, input logic [31:0] a, input logic [255:0] d,
                         input logic [255:0] exp);
        int unsigned c;
        sb_t e;
        @(negedge clk);
        bus_a.cs_i   = 1'b1;
        bus_a.we_i   = we;
        bus_a.addr_i = a;
        bus_a.data_i = d;
        e.is_read = !we;
        e.data    = exp;
        e.ack_cyc = cyc + 1 + LAT;
        sb.push_back(e);
        wait_ack(1'b0, c);
        bus_a.cs_i = 1'b0;
    endtask

    initial begin
        int unsigned a1, a2, k, c, seen;
        sb_t e;

        bus_a.cs_i = 1'b0; bus_a.we_i = 1'b0; bus_a.addr_i = '0; bus_a.data_i = '0;
        bus_b.cs_i = 1'b0; bus_b.we_i = 1'b0; bus_b.addr_i = '0; bus_b.data_i = '0;

        vec[0] = '{we: 1'b1, addr: 32'h0000_0040, data: P_DEAD, exp: '0};
        vec[1] = '{we: 1'b0, addr: 32'h0000_0040, data: '0,     exp: P_DEAD};
        vec[2] = '{we: 1'b1, addr: 32'h0000_0020, data: P_ONE,  exp: '0};
        vec[3] = '{we: 1'b0, addr: 32'h0000_003F, data: '0,     exp: P_ONE};
        vec[4] = '{we: 1'b0, addr: 32'h0000_2020, data: '0,     exp: P_ONE};
        vec[5] = '{we: 1'b1, addr: 32'h0000_00A0, data: P_FIVE, exp: '0};
        vec[6] = '{we: 1'b0, addr: 32'h0000_00A0, data: '0,     exp: P_FIVE};
        vec[7] = '{we: 1'b0, addr: 32'h0000_0040, data: '0,     exp: P_DEAD};

        // Reset for two edges, then idle.
        @(negedge clk);
        chk("rst_ack", 256'(bus_a.ack_o), 256'(0));
        chk("rst_data", bus_a.data_o, '0);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("idle_ack", 256'(bus_a.ack_o), 256'(0));
            chk("idle_data", bus_a.data_o, '0);
        end

        // Table-driven writes/reads, including alignment and aliasing.
        for (int i = 0; i < 8; i++) begin
            req_a(vec[i].we, vec[i].addr, vec[i].data, vec[i].exp);
        end

        // Back-to-back with cs_i held across the ack; mid-WAIT input churn.
        @(negedge clk);
        bus_a.cs_i   = 1'b1;
        bus_a.we_i   = 1'b0;
        bus_a.addr_i = 32'h0000_0020;
        e.is_read = 1'b1; e.data = P_ONE; e.ack_cyc = cyc + 1 + LAT;
        sb.push_back(e);
        wait_ack(1'b0, a1);
        bus_a.addr_i = 32'h0000_0040;
        e.is_read = 1'b1; e.data = P_DEAD; e.ack_cyc = a1 + 2 + LAT;
        sb.push_back(e);
        repeat (4) @(negedge clk);
        bus_a.addr_i = 32'h0000_00A0;
        bus_a.we_i   = 1'b1;
        bus_a.data_i = {8{32'hBAD0_BAD0}};
        wait_ack(1'b0, a2);
        bus_a.cs_i = 1'b0;
        bus_a.we_i = 1'b0;
        chk("b2b_gap", 256'(a2 - a1), 256'(LAT + 2));
        req_a(1'b0, 32'h0000_00A0, '0, P_FIVE);

        // Reset during WAIT of a write: no ack, no commit.
        @(negedge clk);
        bus_a.cs_i   = 1'b1;
        bus_a.we_i   = 1'b1;
        bus_a.addr_i = 32'h0000_00A0;
        bus_a.data_i = 256'h1;
        @(negedge clk);
        bus_a.cs_i = 1'b0;
        bus_a.we_i = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        chk("midrst_data", bus_a.data_o, '0);
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (bus_a.ack_o) seen++;
        end
        chk("midrst_no_ack", 256'(seen), 256'(0));
        req_a(1'b0, 32'h0000_00A0, '0, P_FIVE);

        // LATENCY=1 instance.
        @(negedge clk);
        bus_b.cs_i   = 1'b1;
        bus_b.we_i   = 1'b1;
        bus_b.addr_i = 32'h0000_0060;
        bus_b.data_i = P_Q;
        k = cyc;
        wait_ack(1'b1, c);
        bus_b.cs_i = 1'b0;
        chk("l1_wr_ack_time", 256'(c), 256'(k + 2));
        @(negedge clk);
        bus_b.cs_i = 1'b1;
        bus_b.we_i = 1'b0;
        k = cyc;
        wait_ack(1'b1, c);
        bus_b.cs_i = 1'b0;
        chk("l1_rd_ack_time", 256'(c), 256'(k + 2));
        chk("l1_rd_data", bus_b.data_o, P_Q);
        @(negedge clk);
        chk("l1_ack_width", 256'(bus_b.ack_o), 256'(0));
        chk("l1_hold_data", bus_b.data_o, P_Q);
        repeat (3) @(negedge clk);
        chk("l1_hold_idle", bus_b.data_o, P_Q);
        bus_b.cs_i   = 1'b1;
        bus_b.we_i   = 1'b1;
        bus_b.addr_i = 32'h0000_0080;
        bus_b.data_i = P_R;
        wait_ack(1'b1, c);
        bus_b.cs_i = 1'b0;
        bus_b.we_i = 1'b0;
        chk("l1_hold_write", bus_b.data_o, P_Q);

        repeat (3) @(negedge clk);
        chk("sb_empty", 256'(sb.size()), 256'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
